calc_sched: RTL

CALC_SCHED -- requirements
Module: calc_sched

---
 rtl/calc_sched_if.sv | 25 ++
 rtl/calc_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/calc_sched_if.sv
// Four-port command/response bundle for calc_sched.
// The scheduler side takes the slave modport.
interface calc_sched_if #(
  parameter int CW = 4,
  parameter int DW = 32
);
  logic [4*CW-1:0] req_cmd_in;
  logic [4*DW-1:0] req_data_in;
  logic [7:0]      req_tag_in;
  logic [7:0]      out_resp;
  logic [4*DW-1:0] out_data;
  logic [7:0]      out_tag;
  logic [3:0]      ovf_err;
  logic            busy;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, ovf_err, busy
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, ovf_err, busy
  );
endinterface

// File: rtl/calc_sched.sv
// Four-port two-beat command capture, per-port queues,
// round-robin arbitration onto one shared ALU.
module calc_sched #(
  parameter int APB_CMD_WIDTH  = 4,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic PClk,
  input  logic reset,
  calc_sched_if.slave sbus
);
  localparam int CW  = APB_CMD_WIDTH;
  localparam int DW  = APB_DATA_WIDTH;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CTW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_OP2} st_t;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [1:0]    tag;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } ent_t;

  st_t           r_st  [4];
  logic [CW-1:0] r_cmd [4];
  logic [1:0]    r_tag [4];
  logic [DW-1:0] r_op1 [4];

  ent_t           r_q   [4][FIFO_DEPTH];
  logic [PW-1:0]  r_wp  [4];
  logic [PW-1:0]  r_rp  [4];
  logic [CTW-1:0] r_cnt [4];

  logic [1:0]      r_rr;
  logic [3:0]      r_ovf;
  logic [7:0]      r_resp;
  logic [4*DW-1:0] r_data;
  logic [7:0]      r_otag;

  logic [CW-1:0] w_cmd  [4];
  logic [1:0]    w_tag  [4];
  logic [DW-1:0] w_dat  [4];
  logic          w_pop  [4];
  logic          w_push [4];
  logic          w_drop [4];
  logic          w_full [4];

  logic          w_gnt_v;
  logic [1:0]    w_gnt;
  ent_t          w_head;
  logic [DW:0]   w_sum;
  logic [1:0]    w_rs;
  logic [DW-1:0] w_rd;
  logic          w_busy;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only registered counts are searched, so a
  // same-cycle push is never grantable.
  always_comb begin : gnt_blk
    logic [1:0] idx;
    idx     = '0;
    w_gnt_v = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr + 2'(k);
      if (!w_gnt_v && r_cnt[idx] != '0) begin
        w_gnt_v = 1'b1;
        w_gnt   = idx;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_cmd[n]  = sbus.req_cmd_in[n*CW +: CW];
      w_tag[n]  = sbus.req_tag_in[2*n +: 2];
      w_dat[n]  = sbus.req_data_in[n*DW +: DW];
      w_pop[n]  = w_gnt_v && (w_gnt == 2'(n));
      w_full[n] = (r_cnt[n] == CTW'(FIFO_DEPTH));
      w_push[n] = (r_st[n] == S_OP2) &&
                  (!w_full[n] || w_pop[n]);
      w_drop[n] = (r_st[n] == S_OP2) &&
                  w_full[n] && !w_pop[n];
    end
  end

  assign w_head = r_q[w_gnt][r_rp[w_gnt]];
  assign w_sum  = {1'b0, w_head.op1} + {1'b0, w_head.op2};

  always_comb begin
    w_rs = 2'd2;
    w_rd = '0;
    case (w_head.cmd)
      CW'(1): begin
        if (!w_sum[DW]) begin
          w_rs = 2'd1;
          w_rd = w_sum[DW-1:0];
        end
      end
      CW'(2): begin
        if (w_head.op2 <= w_head.op1) begin
          w_rs = 2'd1;
          w_rd = w_head.op1 - w_head.op2;
        end
      end
      CW'(5): begin
        w_rs = 2'd1;
        w_rd = w_head.op1 << w_head.op2[4:0];
      end
      CW'(6): begin
        w_rs = 2'd1;
        w_rd = w_head.op1 >> w_head.op2[4:0];
      end
      default: begin
        w_rs = 2'd2;
        w_rd = '0;
      end
    endcase
  end

  always_ff @(posedge PClk) begin
    if (reset) begin
      r_rr   <= '0;
      r_ovf  <= '0;
      r_resp <= '0;
      r_data <= '0;
      r_otag <= '0;
      for (int n = 0; n < 4; n++) begin
        r_st[n]  <= S_IDLE;
        r_cmd[n] <= '0;
        r_tag[n] <= '0;
        r_op1[n] <= '0;
        r_wp[n]  <= '0;
        r_rp[n]  <= '0;
        r_cnt[n] <= '0;
      end
    end else begin
      r_resp <= '0;
      r_data <= '0;
      r_otag <= '0;
      if (w_gnt_v) begin
        r_resp[int'(w_gnt)*2 +: 2]  <= w_rs;
        r_data[int'(w_gnt)*DW +: DW] <= w_rd;
        r_otag[int'(w_gnt)*2 +: 2]  <= w_head.tag;
        r_rr <= w_gnt + 2'd1;
      end
      for (int n = 0; n < 4; n++) begin
        if (r_st[n] == S_IDLE) begin
          if (w_cmd[n] != '0) begin
            r_st[n]  <= S_OP2;
            r_cmd[n] <= w_cmd[n];
            r_tag[n] <= w_tag[n];
            r_op1[n] <= w_dat[n];
          end
        end else begin
          r_st[n] <= S_IDLE;
        end
        if (w_push[n]) begin
          r_q[n][r_wp[n]] <= '{
            cmd: r_cmd[n], tag: r_tag[n],
            op1: r_op1[n], op2: w_dat[n]};
          r_wp[n] <= f_inc(r_wp[n]);
        end
        if (w_drop[n])
          r_ovf[n] <= 1'b1;
        if (w_pop[n])
          r_rp[n] <= f_inc(r_rp[n]);
        if (w_push[n] && !w_pop[n])
          r_cnt[n] <= r_cnt[n] + 1'b1;
        else if (!w_push[n] && w_pop[n])
          r_cnt[n] <= r_cnt[n] - 1'b1;
      end
    end
  end

  always_comb begin
    w_busy = |r_resp;
    for (int n = 0; n < 4; n++)
      if (r_st[n] == S_OP2 || r_cnt[n] != '0)
        w_busy = 1'b1;
  end

  assign sbus.out_resp = r_resp;
  assign sbus.out_data = r_data;
  assign sbus.out_tag  = r_otag;
  assign sbus.ovf_err  = r_ovf;
  assign sbus.busy     = w_busy;
endmodule
